csr_trap_ctrl: RTL and testbench
================================

// Module: csr_trap_ctrl
// PURPOSE
//  Machine-mode trap sequencer upstream of the CSR register file. Synchronises external IRQ, qualifies
//  pending interrupts against mstatus.MIE/mie, and on trap entry or MRET drives the CSR write port over
//  a fixed multi-cycle sequence (mepc, mcause, mstatus). It then issues a PC redirect to fetch.
//  Pipeline CSR instructions may use the CSR write port only while busy_o=0.
// PARAMETERS
//  DW     32  data/address width
//  ADDRW  12  CSR address width
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      reset, asynchronous, active-high
//  irq_ext_i      in   1      external interrupt, asynchronous level
//  irq_timer_i    in   1      timer interrupt, clk_i-synchronous level
//  instr_valid_i  in   1      valid instruction in execute; pc_i is its PC
//  pc_i           in   DW     PC of the execute-stage instruction (becomes mepc)
//  is_mret_i      in   1      execute-stage instruction is MRET (qualified by instr_valid_i)
//  mstatus_i      in   DW     current mstatus register value
//  mie_i          in   DW     current mie register value
//  mtvec_i        in   DW     current mtvec register value
//  mepc_i         in   DW     current mepc register value
//  csr_we_o       out  1      CSR write enable (owned by this block while busy_o=1)
//  csr_addr_o     out  ADDRW  CSR write address
//  csr_wdata_o    out  DW     CSR write data
//  mip_o          out  DW     live mip value: bit11 = synced ext IRQ, bit7 = timer, others 0
//  busy_o         out  1      sequence in progress; also flushes/stalls the pipeline
//  redirect_o     out  1      one-cycle pulse: fetch must load redirect_pc_o
//  redirect_pc_o  out  DW     redirect target
// BEHAVIOUR
//  Reset: state=IDLE, sync flops=0, pc_q=0, cause_q=0, mret_q=0; all outputs 0. Applies immediately, even mid-sequence.
//  Synchroniser: 2-flop; ext_s rises on the 2nd rising clk_i edge after irq_ext_i rises.
//  Pending: ext_p = ext_s & mie_i[11]; tmr_p = irq_timer_i & mie_i[7]; take = (ext_p|tmr_p) & mstatus_i[3].
//  IDLE: if instr_valid_i & is_mret_i -> MRET_ST (MRET beats a same-cycle interrupt).
//    Else if take & instr_valid_i -> latch pc_q=pc_i and cause_q, then go to T_EPC.
//    cause_q = 32'h8000000B if ext_p (ext has priority), else 32'h80000007.
//  T_EPC:    we=1, addr=12'h341, wdata=pc_q                                    -> T_CAUSE
//  T_CAUSE:  we=1, addr=12'h342, wdata=cause_q                                 -> T_STAT
//  T_STAT:   we=1, addr=12'h300, wdata=mstatus_i with [7]=mstatus_i[3], [3]=0, [12:11]=2'b11 -> REDIR
//  MRET_ST:  we=1, addr=12'h300, wdata=mstatus_i with [3]=mstatus_i[7], [7]=1, [12:11]=2'b11;
//    sets mret_q -> REDIR
//  REDIR:    redirect_o=1 -> IDLE; mret_q cleared on exit.
//    mret_q=1: redirect_pc_o = mepc_i.
//    mret_q=0, mtvec_i[1:0]==01 (vectored): {mtvec_i[DW-1:2],2'b00} + (cause_q[4:0]<<2).
//    mret_q=0, otherwise (direct): {mtvec_i[DW-1:2],2'b00}.
//  Outputs in IDLE: csr_we_o=0, csr_addr_o=0, csr_wdata_o=0, redirect_pc_o=0.
//  Latency: take in IDLE cycle T -> writes at T+1..T+3, redirect_o at T+4. MRET: write at T+1, redirect at T+2.
//  busy_o=1 in every non-IDLE state; fetch holds and downstream stages flush.
//  IRQ deasserting mid-sequence has no effect (cause already latched). New IRQs are ignored until IDLE.
//  No re-entry: after a trap, mstatus.MIE=0, so no nested take until software or MRET re-enables it.
//  take with instr_valid_i=0: no trap; interrupt stays pending and is re-evaluated each cycle.
// TESTING
//  1 rst_i pulse with irq_ext_i=1 -> all outputs 0 during reset; ext_s not set until 2 edges after release.
//  2 Ext trap: mstatus=0x8, mie=0x800, mtvec=0x200, pc=0x100, irq_ext_i=1.
//    -> writes 0x341=0x100, 0x342=0x8000000B, 0x300=0x1880; redirect 0x200.
//  3 mstatus=0x0, mie=0x880, both IRQs high -> no csr_we_o, busy_o=0, mip_o=0x880.
//  4 Both IRQs, mstatus=0x8, mie=0x880, mtvec=0x201 -> mcause=0x8000000B, redirect 0x22C.
//  5 MRET: mstatus=0x1880, mepc=0x104, same-cycle timer pending -> write 0x300=0x1888, redirect 0x104, no trap that cycle.
//  6 rst_i asserted during T_CAUSE -> csr_we_o drops at once; no 0x300 write; IDLE after release.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: qualifies interrupts, walks the CSR write port
// through mepc/mcause/mstatus on trap entry or MRET, then redirects fetch.
//
// state   | meaning
// IDLE    | waiting for a qualified interrupt or MRET
// T_EPC   | writing mepc with the trapped PC
// T_CAUSE | writing mcause
// T_STAT  | writing mstatus (MPIE<=MIE, MIE<=0, MPP<=M)
// MRET_ST | writing mstatus (MIE<=MPIE, MPIE<=1, MPP<=M)
// REDIR   | one-cycle redirect pulse to fetch
module csr_trap_ctrl #(
  parameter int DW    = 32,
  parameter int ADDRW = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             irq_ext_i,
  input  logic             irq_timer_i,
  input  logic             instr_valid_i,
  input  logic [DW-1:0]    pc_i,
  input  logic             is_mret_i,
  input  logic [DW-1:0]    mstatus_i,
  input  logic [DW-1:0]    mie_i,
  input  logic [DW-1:0]    mtvec_i,
  input  logic [DW-1:0]    mepc_i,
  output logic             csr_we_o,
  output logic [ADDRW-1:0] csr_addr_o,
  output logic [DW-1:0]    csr_wdata_o,
  output logic [DW-1:0]    mip_o,
  output logic             busy_o,
  output logic             redirect_o,
  output logic [DW-1:0]    redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_STAT  = 3'd3,
    MRET_ST = 3'd4,
    REDIR   = 3'd5
  } state_t;

  localparam logic [ADDRW-1:0] A_MSTATUS = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] A_MEPC    = ADDRW'(12'h341);
  localparam logic [ADDRW-1:0] A_MCAUSE  = ADDRW'(12'h342);
  localparam logic [DW-1:0]    C_EXT     = {1'b1, {(DW-6){1'b0}}, 5'h0B};
  localparam logic [DW-1:0]    C_TMR     = {1'b1, {(DW-6){1'b0}}, 5'h07};

  state_t           r_state;
  logic             r_ext_ff1;
  logic             r_ext_s;
  logic [DW-1:0]    r_pc_q;
  logic [DW-1:0]    r_cause_q;
  logic             r_mret_q;
  logic             r_we;
  logic [ADDRW-1:0] r_addr;
  logic [DW-1:0]    r_wdata;
  logic             r_redirect;
  logic [DW-1:0]    r_redirect_pc;

  logic             w_ext_p;
  logic             w_tmr_p;
  logic             w_take;
  logic [DW-1:0]    w_trap_stat;
  logic [DW-1:0]    w_mret_stat;
  logic [DW-1:0]    w_tvec_base;
  logic [DW-1:0]    w_redir_tgt;
  logic             w_unused;

  assign w_ext_p = r_ext_s & mie_i[11];
  assign w_tmr_p = irq_timer_i & mie_i[7];
  assign w_take  = (w_ext_p | w_tmr_p) & mstatus_i[3];

  always_comb begin
    w_trap_stat        = mstatus_i;
    w_trap_stat[7]     = mstatus_i[3];
    w_trap_stat[3]     = 1'b0;
    w_trap_stat[12:11] = 2'b11;
    w_mret_stat        = mstatus_i;
    w_mret_stat[3]     = mstatus_i[7];
    w_mret_stat[7]     = 1'b1;
    w_mret_stat[12:11] = 2'b11;
  end

  // Vectored mode offsets by cause*4; any other mode value falls back to direct.
  assign w_tvec_base = {mtvec_i[DW-1:2], 2'b00};
  always_comb begin
    w_redir_tgt = w_tvec_base;
    if (r_mret_q)
      w_redir_tgt = mepc_i;
    else if (mtvec_i[1:0] == 2'b01)
      w_redir_tgt = w_tvec_base + {{(DW-7){1'b0}}, r_cause_q[4:0], 2'b00};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ext_ff1 <= 1'b0;
      r_ext_s   <= 1'b0;
    end else begin
      r_ext_ff1 <= irq_ext_i;
      r_ext_s   <= r_ext_ff1;
    end
  end

  // Outputs are registered on entry to each state so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_pc_q        <= '0;
      r_cause_q     <= '0;
      r_mret_q      <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_we          <= 1'b0;
          r_addr        <= '0;
          r_wdata       <= '0;
          r_redirect    <= 1'b0;
          r_redirect_pc <= '0;
          if (instr_valid_i && is_mret_i) begin
            r_state  <= MRET_ST;
            r_mret_q <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= A_MSTATUS;
            r_wdata  <= w_mret_stat;
          end else if (w_take && instr_valid_i) begin
            r_state   <= T_EPC;
            r_pc_q    <= pc_i;
            r_cause_q <= w_ext_p ? C_EXT : C_TMR;
            r_we      <= 1'b1;
            r_addr    <= A_MEPC;
            r_wdata   <= pc_i;
          end
        end
        T_EPC: begin
          r_state <= T_CAUSE;
          r_addr  <= A_MCAUSE;
          r_wdata <= r_cause_q;
        end
        T_CAUSE: begin
          r_state <= T_STAT;
          r_addr  <= A_MSTATUS;
          r_wdata <= w_trap_stat;
        end
        T_STAT, MRET_ST: begin
          r_state       <= REDIR;
          r_we          <= 1'b0;
          r_addr        <= '0;
          r_wdata       <= '0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= w_redir_tgt;
        end
        REDIR: begin
          r_state       <= IDLE;
          r_mret_q      <= 1'b0;
          r_redirect    <= 1'b0;
          r_redirect_pc <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign csr_we_o      = r_we;
  assign csr_addr_o    = r_addr;
  assign csr_wdata_o   = r_wdata;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign busy_o        = (r_state != IDLE);
  assign mip_o         = {{(DW-12){1'b0}}, r_ext_s, 11'b0}
                       | {{(DW-8){1'b0}}, irq_timer_i, 7'b0};

  assign w_unused = ^{mie_i[DW-1:12], mie_i[10:8], mie_i[6:0], r_pc_q};

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed-vector bench for csr_trap_ctrl; expected CSR writes and redirects
// are queued by the stimulus and checked by an independent monitor.
module tb_csr_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        irq_ext_i, irq_timer_i, instr_valid_i, is_mret_i;
  logic [31:0] pc_i, mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        csr_we_o, busy_o, redirect_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o, mip_o, redirect_pc_o;

  typedef struct {
    logic        is_redir;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  csr_trap_ctrl #(.DW(32), .ADDRW(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .instr_valid_i(instr_valid_i), .pc_i(pc_i), .is_mret_i(is_mret_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .mip_o(mip_o), .busy_o(busy_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.is_redir = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] pc);
    exp_t e;
    e.is_redir = 1'b1; e.addr = 12'h0; e.data = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every CSR write or redirect pulse must match the head of the queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (csr_we_o || redirect_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: we=%0b addr=0x%03h wdata=0x%08h redir=%0b pc=0x%08h, none expected",
                 csr_we_o, csr_addr_o, csr_wdata_o, redirect_o, redirect_pc_o);
      end else begin
        e = exp_q.pop_front();
        if (e.is_redir) begin
          chk("redirect_seen", {31'b0, redirect_o}, 32'h1);
          chk("redirect_pc", redirect_pc_o, e.data);
        end else begin
          chk("write_seen", {31'b0, csr_we_o}, 32'h1);
          chk("write_addr", {20'b0, csr_addr_o}, {20'b0, e.addr});
          chk("write_data", csr_wdata_o, e.data);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; irq_ext_i = 1'b1; irq_timer_i = 1'b0; instr_valid_i = 1'b0;
    is_mret_i = 1'b0; pc_i = '0; mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;

    // 1: reset with ext IRQ high, then 2-edge synchroniser latency
    cyc(2);
    chk("rst_we", {31'b0, csr_we_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_redirect", {31'b0, redirect_o}, 32'h0);
    chk("rst_mip", mip_o, 32'h0);
    chk("rst_wdata", csr_wdata_o, 32'h0);
    rst_i = 1'b0;
    cyc();
    chk("sync_edge1_mip", mip_o, 32'h0);
    cyc();
    chk("sync_edge2_mip", mip_o, 32'h800);

    // 2: external trap, direct mode
    mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'h200; pc_i = 32'h100;
    push_wr(12'h341, 32'h100);
    push_wr(12'h342, 32'h8000000B);
    push_wr(12'h300, 32'h1880);
    push_redir(32'h200);
    instr_valid_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0;
    chk("t2_busy_T1", {31'b0, busy_o}, 32'h1);
    cyc(3);
    chk("t2_redirect_T4", {31'b0, redirect_o}, 32'h1);
    cyc(2);
    chk("t2_idle_busy", {31'b0, busy_o}, 32'h0);

    // 3: MIE clear -> nothing taken, mip shows both
    mstatus_i = 32'h0; mie_i = 32'h880; irq_timer_i = 1'b1; instr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_no_we", {31'b0, csr_we_o}, 32'h0);
      chk("t3_no_busy", {31'b0, busy_o}, 32'h0);
      chk("t3_mip", mip_o, 32'h880);
    end
    instr_valid_i = 1'b0;

    // 4: both IRQs, ext wins, vectored mode
    mstatus_i = 32'h8; mtvec_i = 32'h201; pc_i = 32'h140;
    push_wr(12'h341, 32'h140);
    push_wr(12'h342, 32'h8000000B);
    push_wr(12'h300, 32'h1880);
    push_redir(32'h22C);
    instr_valid_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0;
    cyc(6);

    // 5: MRET with timer pending but MIE=0
    mstatus_i = 32'h1880; mepc_i = 32'h104; pc_i = 32'h180;
    push_wr(12'h300, 32'h1888);
    push_redir(32'h104);
    instr_valid_i = 1'b1; is_mret_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0; is_mret_i = 1'b0;
    chk("t5_busy", {31'b0, busy_o}, 32'h1);
    cyc();
    chk("t5_redirect_T2", {31'b0, redirect_o}, 32'h1);
    cyc(3);

    // 5b: MRET beats a take that would otherwise fire this cycle
    mstatus_i = 32'h88; mepc_i = 32'h2A0;
    push_wr(12'h300, 32'h1888);
    push_redir(32'h2A0);
    instr_valid_i = 1'b1; is_mret_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0; is_mret_i = 1'b0;
    cyc(4);
    chk("t5b_idle_busy", {31'b0, busy_o}, 32'h0);

    // 6: reset during T_CAUSE aborts the sequence
    irq_timer_i = 1'b0; mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'h200; pc_i = 32'h300;
    push_wr(12'h341, 32'h300);
    instr_valid_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0;
    cyc();
    chk("t6_in_cause_addr", {20'b0, csr_addr_o}, 32'h342);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_we", {31'b0, csr_we_o}, 32'h0);
    chk("t6_rst_busy", {31'b0, busy_o}, 32'h0);
    cyc();
    rst_i = 1'b0;
    cyc();
    chk("t6_after_busy", {31'b0, busy_o}, 32'h0);
    cyc(4);
    chk("t6_after_busy2", {31'b0, busy_o}, 32'h0);

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
